// File: rtl/wb_initiator_seq.sv
// Wishbone classic initiator: accepts one command, runs one bus cycle, returns one response.
// Define WB_INITIATOR_TIMEOUT_EN to compile in the bus-wait timeout (TIMEOUT_CYCLES).
module wb_initiator_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  // Handshakes: a command transfers on any edge where cmd_valid_i && cmd_ready_o;
  // a response transfers on any edge where rsp_valid_o && rsp_ready_i. Once raised,
  // rsp_valid_o and its payload hold until that transfer happens.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_initiator_seq: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        timeout_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        rsp_err_q, rsp_err_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // The last unacknowledged cycle is the one where the count equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_q == ST_BUS) && (wait_cnt_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          wdat_d  = cmd_dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      ST_BUS: begin
        if (wbm_ack_i || timeout_hit) begin
          // Ack has priority over a timeout falling on the same edge.
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          adr_d       = '0;
          wdat_d      = '0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
          rsp_err_d   = !wbm_ack_i;
`endif
        end else begin
`ifdef WB_INITIATOR_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered so it stays low through reset and rises one edge after release.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = wdat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
